// File: rtl/reg_scoreboard.sv
// Register-busy scoreboard for the in-order decode stage: one pending-write counter per register.
// Optional same-cycle write-back bypass of the source check is enabled by SCOREBOARD_WB_BYPASS_EN.
module reg_scoreboard #(
   parameter int NUM_REGS   = 32,
   parameter int REGNO_BITS = 5,
   parameter int CNT_BITS   = 3,
   parameter int NUM_RD     = 2,
   parameter int NUM_WB     = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         issue_valid,
   input  logic                         issue_wr,
   input  logic [REGNO_BITS-1:0]        issue_rd,
   input  logic [NUM_RD-1:0]            src_valid,
   input  logic [NUM_RD*REGNO_BITS-1:0] src_regno,
   input  logic [NUM_WB-1:0]            wb_valid,
   input  logic [NUM_WB*REGNO_BITS-1:0] wb_regno,
   output logic                         stall,
   output logic                         issue_accept,
   output logic [NUM_REGS-1:0]          busy_vec,
   output logic                         underflow_err,
   output logic                         overflow_err
);

   localparam int DEC_BITS = $clog2(NUM_WB + 1);
   localparam int SUM_BITS = CNT_BITS + 2;
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   logic [CNT_BITS-1:0] cnt_q [NUM_REGS];
   logic [CNT_BITS-1:0] cnt_d [NUM_REGS];
   logic [CNT_BITS-1:0] effCnt [NUM_REGS];
   logic [DEC_BITS-1:0] dec [NUM_REGS];
   logic [NUM_REGS-1:0] inc;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                underflow_q, underflow_d;
   logic                overflow_q, overflow_d;
   logic                srcBusy;
   logic                dstFull;

   // Count how many write-back ports release each register; x0 never collects releases.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         dec[r] = '0;
         for (int p = 0; p < NUM_WB; p++) begin
            if (r != 0 && wb_valid[p] &&
                wb_regno[p*REGNO_BITS +: REGNO_BITS] == REGNO_BITS'(r)) begin
               dec[r] = dec[r] + DEC_BITS'(1);
            end
         end
      end
   end

   // Count seen by the source check; the bypass build lets this cycle's releases count already.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
         if (SUM_BITS'(dec[r]) >= SUM_BITS'(cnt_q[r])) begin
            effCnt[r] = '0;
         end else begin
            effCnt[r] = cnt_q[r] - CNT_BITS'(dec[r]);
         end
`else
         effCnt[r] = cnt_q[r];
`endif
      end
   end

   always_comb begin
      logic [REGNO_BITS-1:0] idx;
      srcBusy = 1'b0;
      idx     = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         idx = src_regno[p*REGNO_BITS +: REGNO_BITS];
         if (src_valid[p] && idx != '0 && int'(idx) < NUM_REGS) begin
            if (effCnt[idx] != '0) begin
               srcBusy = 1'b1;
            end
         end
      end
      dstFull = 1'b0;
      if (issue_wr && issue_rd != '0 && int'(issue_rd) < NUM_REGS) begin
         dstFull = (cnt_q[issue_rd] == CNT_MAX);
      end
   end

   assign stall        = issue_valid & (srcBusy | dstFull);
   assign issue_accept = issue_valid & ~stall;

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         inc[r] = issue_accept && issue_wr && (issue_rd == REGNO_BITS'(r)) && (r != 0);
      end
   end

   // Widened signed update so negative and over-max results can be detected and clamped.
   always_comb begin
      logic [SUM_BITS-1:0] sum;
      sum         = '0;
      underflow_d = underflow_q;
      overflow_d  = overflow_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         sum = SUM_BITS'(cnt_q[r]) + SUM_BITS'(inc[r]) - SUM_BITS'(dec[r]);
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (sum[SUM_BITS-1]) begin
            cnt_d[r]    = '0;
            underflow_d = 1'b1;
         end else if (sum > SUM_BITS'(CNT_MAX)) begin
            cnt_d[r]   = CNT_MAX;
            overflow_d = 1'b1;
         end else begin
            cnt_d[r] = sum[CNT_BITS-1:0];
         end
         busy_d[r] = (cnt_d[r] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q      <= '0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end

   assign busy_vec      = busy_q;
   assign underflow_err = underflow_q;
   assign overflow_err  = overflow_q;

endmodule
